adc_feeder: RTL

ADC_FEEDER -- requirements
Module: adc_feeder

---
 rtl/correlator_pkg.sv | 27 ++
 rtl/sample_fifo.sv | 56 +++++
 rtl/adc_feeder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/correlator_pkg.sv
// Shared correlator definitions: feeder register offsets, CTRL bit positions,
// pacing FSM states and the offset-binary conversion helper.
package correlator_pkg;

  localparam logic [31:0] OFS_CTRL     = 32'h00;
  localparam logic [31:0] OFS_INTERVAL = 32'h04;
  localparam logic [31:0] OFS_STATUS   = 32'h08;
  localparam logic [31:0] OFS_PUSHCNT  = 32'h0C;
  localparam logic [31:0] OFS_DROPCNT  = 32'h10;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_OBIN  = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int CTRL_BP    = 3;
  localparam int STATUS_OVF = 16;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } pace_state_e;

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [15:0] obin_convert(input logic [15:0] s, input logic obin);
    return obin ? {~s[15], s[14:0]} : s;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with combinational head data, one-cycle flush and
// an occupancy level that ranges 0..DEPTH.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = level[AW];

endmodule

// File: rtl/adc_feeder.sv
// ADC feeder: buffers converter samples and releases them to the correlators
// at a programmable minimum interval, with a small bus-mapped register block.
module adc_feeder
  import correlator_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [31:0] BASE  = 32'hFE000800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic [15:0] AdcIn,
  input  logic        AdcValid,
  output logic        AdcReady,
  output logic [15:0] ADC,
  output logic        PushADC,
  output logic        Overflow
);

  localparam int AW = $clog2(DEPTH);

  logic        en, obin, bp, ovf;
  logic [15:0] interval, cnt, cnt_next, ival_m1;
  logic [31:0] push_cnt, drop_cnt;
  pace_state_e state, state_next;

  logic        pop, fifo_push, drop, offered, flush;
  logic [15:0] fifo_dout;
  logic [AW:0] level;
  logic        empty, full;
  logic        wr_ctrl, wr_interval, wr_status, wr_pushcnt, wr_dropcnt;

  assign wr_ctrl     = write && (addr == BASE + OFS_CTRL);
  assign wr_interval = write && (addr == BASE + OFS_INTERVAL);
  assign wr_status   = write && (addr == BASE + OFS_STATUS);
  assign wr_pushcnt  = write && (addr == BASE + OFS_PUSHCNT);
  assign wr_dropcnt  = write && (addr == BASE + OFS_DROPCNT);
  assign flush       = wr_ctrl && Wdata[CTRL_FLUSH];

  assign ival_m1 = (interval == 16'd0) ? 16'd0 : interval - 16'd1;

  // A full FIFO still takes a sample when the same cycle pops; flush discards it silently.
  assign AdcReady  = rst && (bp ? !full : 1'b1);
  assign offered   = AdcValid && AdcReady && !flush;
  assign fifo_push = offered && (!full || pop);
  assign drop      = offered && full && !pop;
  assign Overflow  = ovf;

  sample_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .din   (AdcIn),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_WAIT;
          cnt_next   = ival_m1;
        end
      end
      ST_WAIT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (flush) begin
          cnt_next = ival_m1;
        end else if (cnt != 16'd0) begin
          cnt_next = cnt - 16'd1;
        end else if (!empty) begin
          pop      = 1'b1;
          cnt_next = ival_m1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ADC     <= '0;
      PushADC <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      PushADC <= pop;
      if (pop) ADC <= obin_convert(fifo_dout, obin);
    end
  end

  // Bus writes win over same-cycle hardware increments; a drop wins over an OVF clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en       <= 1'b0;
      obin     <= 1'b0;
      bp       <= 1'b0;
      interval <= '0;
      ovf      <= 1'b0;
      push_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= Wdata[CTRL_EN];
        obin <= Wdata[CTRL_OBIN];
        bp   <= Wdata[CTRL_BP];
      end
      if (wr_interval) interval <= Wdata[15:0];
      if (drop) ovf <= 1'b1;
      else if (wr_status && Wdata[STATUS_OVF]) ovf <= 1'b0;
      push_cnt <= wr_pushcnt ? Wdata : push_cnt + {31'd0, pop};
      drop_cnt <= wr_dropcnt ? Wdata : drop_cnt + {31'd0, drop};
    end
  end

  always_comb begin
    Rdata = '0;
    if (read && rst) begin
      case (addr)
        BASE + OFS_CTRL:     Rdata = {28'd0, bp, 1'b0, obin, en};
        BASE + OFS_INTERVAL: Rdata = {16'd0, interval};
        BASE + OFS_STATUS:   Rdata = {15'd0, ovf, 6'd0, full, empty, 8'(level)};
        BASE + OFS_PUSHCNT:  Rdata = push_cnt;
        BASE + OFS_DROPCNT:  Rdata = drop_cnt;
        default:             Rdata = '0;
      endcase
    end
  end

endmodule
